// File: rtl/coin_round_ctrl_if.sv
// Signal bundle between the overlap/frame-timing side and coin_round_ctrl.
// master drives the round inputs; slave is the controller.
interface coin_round_ctrl_if;
    logic        frame_tick;
    logic        game_en;
    logic        mario_hit;
    logic        coin_visible;
    logic        respawn;
    logic [2:0]  slot;
    logic [11:0] score;
    logic        score_pulse;

    modport master (
        output frame_tick, game_en, mario_hit,
        input  coin_visible, respawn, slot, score, score_pulse
    );

    modport slave (
        input  frame_tick, game_en, mario_hit,
        output coin_visible, respawn, slot, score, score_pulse
    );
endinterface

// File: rtl/coin_round_ctrl.sv
// Coin life-cycle sequencer: collect detection, BCD score, timed hide, respawn slot pick.
// Optional macro COIN_SCORE_SAT_EN: score saturates at 999 instead of wrapping to 000.
module coin_round_ctrl #(
    parameter int unsigned HIDE_FRAMES = 30,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    coin_round_ctrl_if.slave bus_if
);
    localparam int unsigned SCORE_W = 12;
    localparam int unsigned SLOT_W  = 3;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned LFSR_W  = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHOW    = 3'd1,
        COLLECT = 3'd2,
        HIDE    = 3'd3,
        PICK    = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic                hit_q;
    logic                coin_visible_q, coin_visible_d;
    logic                respawn_q, respawn_d;
    logic                score_pulse_q, score_pulse_d;
    logic                collect;
    logic [SLOT_W-1:0]   cand;

    // Three-digit BCD increment with carry ripple between digits.
    function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
        logic [3:0] o;
        logic [3:0] t;
        logic [3:0] h;
        o = v[3:0];
        t = v[7:4];
        h = v[11:8];
`ifdef COIN_SCORE_SAT_EN
        if (v == 12'h999) begin
            return v;
        end
`endif
        if (o == 4'd9) begin
            o = 4'd0;
            if (t == 4'd9) begin
                t = 4'd0;
                h = (h == 4'd9) ? 4'd0 : h + 4'd1;
            end else begin
                t = t + 4'd1;
            end
        end else begin
            o = o + 4'd1;
        end
        return {h, t, o};
    endfunction

    assign collect = bus_if.mario_hit & ~hit_q;
    assign cand    = lfsr_q[SLOT_W-1:0];
    assign lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            lfsr_q         <= LFSR_SEED;
            cnt_q          <= '0;
            slot_q         <= '0;
            score_q        <= '0;
            hit_q          <= 1'b0;
            coin_visible_q <= 1'b0;
            respawn_q      <= 1'b0;
            score_pulse_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            lfsr_q         <= lfsr_d;
            cnt_q          <= cnt_d;
            slot_q         <= slot_d;
            score_q        <= score_d;
            hit_q          <= bus_if.mario_hit;
            coin_visible_q <= coin_visible_d;
            respawn_q      <= respawn_d;
            score_pulse_q  <= score_pulse_d;
        end
    end

    // Next state and registered-output values; losing game_en overrides everything.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        slot_d        = slot_q;
        score_d       = score_q;
        respawn_d     = 1'b0;
        score_pulse_d = 1'b0;
        if (!bus_if.game_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    score_d = '0;
                    slot_d  = '0;
                    state_d = SHOW;
                end
                SHOW: begin
                    if (collect) begin
                        score_d       = bcd_inc(score_q);
                        score_pulse_d = 1'b1;
                        cnt_d         = CNT_W'(HIDE_FRAMES);
                        state_d       = COLLECT;
                    end
                end
                COLLECT: state_d = HIDE;
                HIDE: begin
                    if (cnt_q == '0) begin
                        state_d = PICK;
                    end else if (bus_if.frame_tick) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                PICK: begin
                    if (cand != slot_q) begin
                        slot_d    = cand;
                        respawn_d = 1'b1;
                        state_d   = SHOW;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // Visible only once SHOW has been held a full cycle, giving the renderer a move cycle.
        coin_visible_d = (state_q == SHOW) && (state_d == SHOW);
    end

    assign bus_if.coin_visible = coin_visible_q;
    assign bus_if.respawn      = respawn_q;
    assign bus_if.slot         = slot_q;
    assign bus_if.score        = score_q;
    assign bus_if.score_pulse  = score_pulse_q;
endmodule

// File: tb/tb_coin_round_ctrl.sv
// Bench for coin_round_ctrl: two instances (HIDE_FRAMES=3 and 0) against a decimal score
// model and slot-sequence properties, with randomized hit timing and frame spacing.
module tb_coin_round_ctrl;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cnt3     = 0;
    int   cnt0     = 0;
    int   prev3    = 0;

    coin_round_ctrl_if if3();
    coin_round_ctrl_if if0();

    coin_round_ctrl #(.HIDE_FRAMES(3)) dut3 (.clk(clk), .rst(rst), .bus_if(if3));
    coin_round_ctrl #(.HIDE_FRAMES(0)) dut0 (.clk(clk), .rst(rst), .bus_if(if0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    // Expected BCD score after n collections since the round started.
    function automatic logic [11:0] exp_bcd(input int n);
        int v;
`ifdef COIN_SCORE_SAT_EN
        v = (n > 999) ? 999 : n;
`else
        v = n % 1000;
`endif
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        if3.game_en = 0; if3.mario_hit = 0; if3.frame_tick = 0;
        if0.game_en = 0; if0.mario_hit = 0; if0.frame_tick = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({if3.coin_visible, if3.respawn, if3.slot, if3.score, if3.score_pulse} !== 17'd0 ||
            {if0.coin_visible, if0.respawn, if0.slot, if0.score, if0.score_pulse} !== 17'd0) begin
            failures++;
            $display("FAIL reset_outputs got vis=%b resp=%b slot=%0d score=%h pulse=%b required all zero",
                     if3.coin_visible, if3.respawn, if3.slot, if3.score, if3.score_pulse);
        end
        rst = 1'b0;
        @(negedge clk);
        if3.game_en = 1; if0.game_en = 1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (if3.coin_visible !== 1'b1 || if3.slot !== 3'd0 || if3.score !== 12'h000 || if3.respawn !== 1'b0) begin
            failures++;
            $display("FAIL start_show got vis=%b slot=%0d score=%h required vis=1 slot=0 score=000",
                     if3.coin_visible, if3.slot, if3.score);
        end
        cnt3 = 0; prev3 = 0;
    endtask

    // One collection on the HIDE_FRAMES=3 instance with full timing checks.
    task automatic collect3(input bit keep_hit);
        int  waitc;
        int  ticks;
        bit  seen;
        waitc = 0;
        while (if3.coin_visible !== 1'b1 && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        checks++;
        if (if3.coin_visible !== 1'b1) begin
            failures++;
            $display("FAIL collect_ready vis=%b required 1", if3.coin_visible);
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if3.mario_hit = 1;
        @(negedge clk);
        cnt3++;
        checks++;
        if (if3.score_pulse !== 1'b1 || if3.score !== exp_bcd(cnt3) || if3.coin_visible !== 1'b0) begin
            failures++;
            $display("FAIL collect_edge n=%0d got pulse=%b score=%h vis=%b required pulse=1 score=%h vis=0",
                     cnt3, if3.score_pulse, if3.score, if3.coin_visible, exp_bcd(cnt3));
        end
        if (!keep_hit) if3.mario_hit = 0;
        if3.frame_tick = 1'($urandom_range(0, 1));
        @(negedge clk);
        if3.frame_tick = 0;
        checks++;
        if (if3.score_pulse !== 1'b0) begin
            failures++;
            $display("FAIL pulse_width got pulse=%b required 0", if3.score_pulse);
        end
        ticks = 0; seen = 0; waitc = 0;
        while (!seen && waitc < 200) begin
            if (ticks < 3 && $urandom_range(0, 1) == 1) begin
                if3.frame_tick = 1;
                ticks++;
            end else begin
                if3.frame_tick = 0;
            end
            @(negedge clk);
            waitc++;
            if (if3.respawn === 1'b1) seen = 1;
        end
        if3.frame_tick = 0;
        checks++;
        if (!seen || ticks != 3 || if3.slot === 3'(prev3) || if3.coin_visible !== 1'b0) begin
            failures++;
            $display("FAIL respawn seen=%b ticks=%0d slot=%0d prev=%0d vis=%b required seen=1 ticks=3 slot!=prev vis=0",
                     seen, ticks, if3.slot, prev3, if3.coin_visible);
        end
        prev3 = int'(if3.slot);
        @(negedge clk);
        checks++;
        if (if3.coin_visible !== 1'b1 || if3.respawn !== 1'b0) begin
            failures++;
            $display("FAIL after_respawn got vis=%b resp=%b required vis=1 resp=0", if3.coin_visible, if3.respawn);
        end
    endtask

    task automatic test_collect;
        collect3(1'b0);
    endtask

    task automatic test_no_retrigger;
        collect3(1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (if3.score_pulse !== 1'b0 || if3.coin_visible !== 1'b1 || if3.score !== exp_bcd(cnt3)) begin
                failures++;
                $display("FAIL no_retrigger got pulse=%b vis=%b score=%h required pulse=0 vis=1 score=%h",
                         if3.score_pulse, if3.coin_visible, if3.score, exp_bcd(cnt3));
            end
        end
        if3.mario_hit = 0;
        @(negedge clk);
        collect3(1'b0);
    endtask

    task automatic test_abort;
        logic [11:0] held;
        logic [2:0]  held_slot;
        if3.mario_hit = 1;
        @(negedge clk);
        cnt3++;
        if3.mario_hit = 0;
        @(negedge clk);
        held = if3.score; held_slot = if3.slot;
        checks++;
        if (held !== exp_bcd(cnt3)) begin
            failures++;
            $display("FAIL abort_pre score=%h required %h", held, exp_bcd(cnt3));
        end
        if3.game_en = 0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            if3.frame_tick = 1'(i % 2);
            @(negedge clk);
            checks++;
            if (if3.coin_visible !== 1'b0 || if3.respawn !== 1'b0 || if3.score !== held || if3.slot !== held_slot) begin
                failures++;
                $display("FAIL abort_hold got vis=%b resp=%b score=%h slot=%0d required vis=0 resp=0 score=%h slot=%0d",
                         if3.coin_visible, if3.respawn, if3.score, if3.slot, held, held_slot);
            end
        end
        if3.frame_tick = 0;
        if3.game_en = 1;
        @(negedge clk);
        checks++;
        if (if3.score !== 12'h000 || if3.slot !== 3'd0) begin
            failures++;
            $display("FAIL restart got score=%h slot=%0d required 000 and 0", if3.score, if3.slot);
        end
        cnt3 = 0; prev3 = 0;
        @(negedge clk);
        checks++;
        if (if3.coin_visible !== 1'b1) begin
            failures++;
            $display("FAIL restart_vis got %b required 1", if3.coin_visible);
        end
        // game_en falling together with a collect edge: no score change
        if3.mario_hit = 1; if3.game_en = 0;
        @(negedge clk);
        checks++;
        if (if3.score_pulse !== 1'b0 || if3.score !== 12'h000 || if3.coin_visible !== 1'b0) begin
            failures++;
            $display("FAIL abort_collect got pulse=%b score=%h vis=%b required 0 000 0",
                     if3.score_pulse, if3.score, if3.coin_visible);
        end
        if3.mario_hit = 0;
        @(negedge clk);
        if3.game_en = 1;
        @(negedge clk);
    endtask

    task automatic test_bcd_carry;
        while (cnt3 < 100) collect3(1'b0);
        checks++;
        if (if3.score !== 12'h100) begin
            failures++;
            $display("FAIL bcd_100 got %h required 100", if3.score);
        end
        while (cnt3 < 1000) collect3(1'b0);
        checks++;
        if (if3.score !== exp_bcd(1000)) begin
            failures++;
            $display("FAIL bcd_wrap got %h required %h", if3.score, exp_bcd(1000));
        end
        collect3(1'b0);
        checks++;
        if (if3.score !== exp_bcd(1001)) begin
            failures++;
            $display("FAIL bcd_after_wrap got %h required %h", if3.score, exp_bcd(1001));
        end
    endtask

    task automatic test_slot_unique;
        logic [7:0] seen_mask;
        int prev;
        int waitc;
        bit seen;
        seen_mask = 8'h00;
        prev = 0;
        cnt0 = 0;
        for (int i = 0; i < 500; i++) begin
            waitc = 0;
            while (if0.coin_visible !== 1'b1 && waitc < 50) begin
                @(negedge clk);
                waitc++;
            end
            repeat ($urandom_range(0, 1)) @(negedge clk);
            if0.mario_hit = 1;
            @(negedge clk);
            if0.mario_hit = 0;
            cnt0++;
            checks++;
            if (if0.score_pulse !== 1'b1 || if0.score !== exp_bcd(cnt0)) begin
                failures++;
                $display("FAIL slot_collect n=%0d got pulse=%b score=%h required 1 %h",
                         cnt0, if0.score_pulse, if0.score, exp_bcd(cnt0));
            end
            seen = 0; waitc = 0;
            while (!seen && waitc < 300) begin
                @(negedge clk);
                waitc++;
                if (if0.respawn === 1'b1) seen = 1;
            end
            checks++;
            if (!seen || if0.slot === 3'(prev)) begin
                failures++;
                $display("FAIL slot_unique n=%0d seen=%b slot=%0d prev=%0d required seen=1 slot!=prev",
                         cnt0, seen, if0.slot, prev);
            end
            if (seen) begin
                seen_mask[if0.slot] = 1'b1;
                prev = int'(if0.slot);
            end
        end
        checks++;
        if (seen_mask !== 8'hFF) begin
            failures++;
            $display("FAIL slot_coverage got mask=%h required ff", seen_mask);
        end
    endtask

    task automatic test_reset_midround;
        @(negedge clk);
        if3.mario_hit = 1;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({if3.coin_visible, if3.respawn, if3.slot, if3.score, if3.score_pulse} !== 17'd0) begin
            failures++;
            $display("FAIL async_reset got vis=%b resp=%b slot=%0d score=%h pulse=%b required all zero",
                     if3.coin_visible, if3.respawn, if3.slot, if3.score, if3.score_pulse);
        end
        if3.mario_hit = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_collect();
        test_no_retrigger();
        test_abort();
        test_bcd_carry();
        test_slot_unique();
        test_reset_midround();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
